reg_readout_serializer: RTL

- Reader and transmitter counterpart to the CPU's 16-bit load-on-strobe registers.
- On request, it snapshots a register's parallel value and streams it out serially, MSB first, over a valid/ready handshake.
- Intended use: debug/scan readout of architectural registers (PC, IR, ACC) to an off-core monitor.
- Sits beside the register bank. It only observes register outputs and never writes them.

---
 rtl/cpu_debug_pkg.sv | 15 +
 rtl/shift_reg_16.sv | 23 ++
 rtl/reg_readout_serializer.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug readout path: FSM state encoding and
// default sizing for the register serializer.
package cpu_debug_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CNT_W = 5;
  localparam int unsigned LAST_IDX  = DEF_WIDTH - 1;

endpackage

// File: rtl/shift_reg_16.sv
// Parallel-load, shift-left register with zero fill; load wins over shift.
module shift_reg_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/reg_readout_serializer.sv
// Snapshots an observed register on request and streams it out MSB first
// over a valid/ready handshake; outputs decode registered state only.
module reg_readout_serializer
  import cpu_debug_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] d,
  output logic             sdo,
  output logic             sdo_valid,
  input  logic             sdo_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] snap
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] snap_q;
  logic             load;
  logic             shift;

  shift_reg_16 #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .d    (d),
    .q    (sr_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      count  <= '0;
      snap_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (load) begin
        snap_q <= d;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          load      = 1'b1;
          count_nxt = '0;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A beat moves only when the sink is ready; otherwise everything holds.
        if (sdo_ready) begin
          shift     = 1'b1;
          count_nxt = count + CNT_W'(1);
          if (count == LAST_CNT) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign sdo       = sr_q[WIDTH-1];
  assign sdo_valid = (state == S_SHIFT);
  assign busy      = (state == S_SHIFT) || (state == S_DONE);
  assign done      = (state == S_DONE);
  assign snap      = snap_q;

endmodule
